// File: rtl/speed_uart_tx.sv
// Byte-serial UART transmitter (8N1 by default) with a valid/ready byte handshake,
// plus the speed-code to ASCII digit mapper. Define SPEED_UART_TX_PARITY_EN for 8E1 framing.
module speed_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int BITS_N       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BITS_N-1:0] data_tx,
    input  logic              valid,
    output logic              ready,
    output logic              uart_out,
    input  logic [2:0]        speed,
    output logic [7:0]        ascii_speed
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(BITS_N + 1);
    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(BITS_N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            state;
    logic [CW-1:0]     clk_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [BITS_N-1:0] shift_reg;
`ifdef SPEED_UART_TX_PARITY_EN
    logic              parity_bit;
`endif

    // Handshake: a byte transfers on any rising edge where valid && ready; ready is
    // high only in IDLE, so valid while busy is ignored and nothing is queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            uart_out  <= 1'b1;
            ready     <= 1'b1;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
`ifdef SPEED_UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    uart_out <= 1'b1;
                    ready    <= 1'b1;
                    clk_cnt  <= '0;
                    bit_cnt  <= '0;
                    if (valid && ready) begin
                        shift_reg <= data_tx;
`ifdef SPEED_UART_TX_PARITY_EN
                        parity_bit <= ^data_tx;
`endif
                        state    <= S_START;
                        uart_out <= 1'b0;
                        ready    <= 1'b0;
                    end
                end
                S_START: begin
                    if (clk_cnt == CLK_LAST) begin
                        clk_cnt   <= '0;
                        state     <= S_DATA;
                        uart_out  <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (clk_cnt == CLK_LAST) begin
                        clk_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
`ifdef SPEED_UART_TX_PARITY_EN
                            state    <= S_PARITY;
                            uart_out <= parity_bit;
`else
                            state    <= S_STOP;
                            uart_out <= 1'b1;
`endif
                        end else begin
                            bit_cnt   <= bit_cnt + BW'(1);
                            uart_out  <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
`ifdef SPEED_UART_TX_PARITY_EN
                S_PARITY: begin
                    if (clk_cnt == CLK_LAST) begin
                        clk_cnt  <= '0;
                        state    <= S_STOP;
                        uart_out <= 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
`endif
                S_STOP: begin
                    // ready rises on the edge that ends the stop bit, giving a 1-clock idle gap
                    if (clk_cnt == CLK_LAST) begin
                        clk_cnt  <= '0;
                        state    <= S_IDLE;
                        ready    <= 1'b1;
                        uart_out <= 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    ready    <= 1'b1;
                    uart_out <= 1'b1;
                    clk_cnt  <= '0;
                    bit_cnt  <= '0;
                end
            endcase
        end
    end

    assign ascii_speed = 8'h30 + {5'b00000, speed};

endmodule

// File: tb/tb_speed_uart_tx.sv
// Testbench for speed_uart_tx: table-driven frames and speed digits, directed corner
// sequences, and a per-cycle queue-based line model checked every clock.
module tb_speed_uart_tx;

    localparam int C = 4;
    localparam int N = 8;
`ifdef SPEED_UART_TX_PARITY_EN
    localparam int NSLOT = N + 3;
`else
    localparam int NSLOT = N + 2;
`endif
    localparam int READY_AT = 1 + NSLOT * C;
    localparam int BUDGET   = 200;

    logic       clk;
    logic       rst;
    logic [7:0] data_tx;
    logic       valid;
    logic       ready;
    logic       uart_out;
    logic [2:0] speed;
    logic [7:0] ascii_speed;

    speed_uart_tx #(.CLKS_PER_BIT(C), .BITS_N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .data_tx     (data_tx),
        .valid       (valid),
        .ready       (ready),
        .uart_out    (uart_out),
        .speed       (speed),
        .ascii_speed (ascii_speed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the line is a queue of per-clock levels built from the framing rules.
    logic line_q[$];
    logic exp_uart  = 1'b1;
    logic exp_ready = 1'b1;
    bit   chk_en    = 1'b0;

    task automatic push_frame(input logic [7:0] b);
        for (int c = 0; c < C; c++) line_q.push_back(1'b0);
        for (int i = 0; i < N; i++)
            for (int c = 0; c < C; c++) line_q.push_back(b[i]);
`ifdef SPEED_UART_TX_PARITY_EN
        for (int c = 0; c < C; c++) line_q.push_back(^b);
`endif
        for (int c = 0; c < C; c++) line_q.push_back(1'b1);
    endtask

    always @(posedge clk) begin
        if (rst) begin
            line_q.delete();
            exp_uart  <= 1'b1;
            exp_ready <= 1'b1;
        end else begin
            if (exp_ready && valid) push_frame(data_tx);
            if (line_q.size() > 0) begin
                exp_uart  <= line_q.pop_front();
                exp_ready <= 1'b0;
            end else begin
                exp_uart  <= 1'b1;
                exp_ready <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_line", uart_out, exp_uart);
            check("model_ready", ready, exp_ready);
        end
    end

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;  // slot levels: [0]=start, [8:1]=data, [9]=stop
        logic       par;
    } frame_vec_t;

    typedef struct {
        logic [2:0] spd;
        logic [7:0] asc;
    } spd_vec_t;

    frame_vec_t fv[6];
    spd_vec_t   sv[8];

    function automatic logic slot_level(input frame_vec_t v, input int s);
        if (s <= N) return v.line[s];
`ifdef SPEED_UART_TX_PARITY_EN
        if (s == N + 1) return v.par;
`endif
        return v.line[9];
    endfunction

    task automatic wait_ready(input string name);
        int t = 0;
        while (ready !== 1'b1 && t < BUDGET) begin
            @(negedge clk);
            t++;
        end
        if (t >= BUDGET) check({name, "_timeout"}, 0, 1);
    endtask

    // Sends one byte and samples each bit slot mid-bit plus the ready-return cycle.
    task automatic send_vec(input frame_vec_t v);
        int s;
        @(negedge clk);
        data_tx = v.data;
        valid   = 1'b1;
        wait_ready("send");
        @(posedge clk);
        for (int j = 1; j <= READY_AT; j++) begin
            @(negedge clk);
            if (j == 1) begin
                valid   = 1'b0;
                data_tx = 8'($urandom);
            end
            if (j >= 2 && (j - 2) % C == 0) begin
                s = (j - 2) / C;
                if (s < NSLOT) check($sformatf("slot%0d_byte%02h", s, v.data), uart_out, slot_level(v, s));
            end
            if (j == READY_AT - 1) check("ready_low_last", ready, 0);
            if (j == READY_AT) begin
                check("ready_return", ready, 1);
                check("idle_after", uart_out, 1);
            end
        end
    endtask

    logic [7:0] b3[3];
    int cnt;

    initial begin
        fv[0] = '{8'h7B, 10'b1011110110, 1'b0};
        fv[1] = '{8'h31, 10'b1001100010, 1'b1};
        fv[2] = '{8'h0A, 10'b1000010100, 1'b0};
        fv[3] = '{8'h00, 10'b1000000000, 1'b0};
        fv[4] = '{8'hFF, 10'b1111111110, 1'b0};
        fv[5] = '{8'h80, 10'b1100000000, 1'b1};
        for (int i = 0; i < 8; i++) sv[i] = '{3'(i), 8'h30 + 8'(i)};
        b3[0] = 8'h7B;
        b3[1] = 8'h22;
        b3[2] = 8'h54;

        rst = 1'b1; valid = 1'b0; data_tx = 8'h00; speed = 3'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_line", uart_out, 1);
        check("rst_ready", ready, 1);
        rst = 1'b0;

        // Idle with valid low
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_line", uart_out, 1);
            check("idle_ready", ready, 1);
        end

        // Frame table
        for (int i = 0; i < 6; i++) send_vec(fv[i]);

        // Back-to-back frames with valid held high and data changing after each accept
        @(negedge clk);
        wait_ready("b2b");
        valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_tx = b3[i];
            @(posedge clk);
            @(negedge clk);
            data_tx = 8'($urandom);
            cnt = 1;
            while (ready !== 1'b1 && cnt < BUDGET) begin
                @(negedge clk);
                cnt++;
            end
            check("b2b_ready_at", cnt, READY_AT);
            check("b2b_gap_line", uart_out, 1);
        end
        valid = 1'b0;

        // Reset in the middle of DATA aborts the frame
        @(negedge clk);
        data_tx = 8'h00;
        valid   = 1'b1;
        wait_ready("abort");
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        repeat (12) @(negedge clk);
        check("mid_data_low", uart_out, 0);
        check("mid_data_busy", ready, 0);
        rst = 1'b1;
        @(negedge clk);
        check("abort_line", uart_out, 1);
        check("abort_ready", ready, 1);
        rst = 1'b0;
        send_vec(fv[2]);

        // valid && ready on the reset edge: reset wins
        @(negedge clk);
        data_tx = 8'hFF;
        valid   = 1'b1;
        rst     = 1'b1;
        @(negedge clk);
        check("rstwin_ready", ready, 1);
        rst   = 1'b0;
        valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rstwin_no_frame", uart_out, 1);
        end

        // Speed digit table
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            speed = sv[i].spd;
            #1;
            check($sformatf("ascii_speed%0d", sv[i].spd), ascii_speed, sv[i].asc);
        end

        // Random traffic: valid pulses land both while idle and while busy
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            valid   = ($urandom_range(0, 7) == 0);
            data_tx = 8'($urandom);
            speed   = 3'($urandom_range(0, 7));
            #1;
            check("rand_ascii", ascii_speed, 8'h30 + {5'd0, speed});
        end
        @(negedge clk);
        valid = 1'b0;
        wait_ready("drain");
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
